// File: rtl/change_dispenser_if.sv
// Coin-path bundle between the change dispenser, the coin counter and the ejector.
// Latency: none, wires only.
// Backpressure: eject_ready/eject_done carry the ejector handshake.
interface change_dispenser_if #(
    parameter int WIDTH = 6
);
    logic             coin_return;
    logic [WIDTH-1:0] coinCount;
    logic             eject_ready;
    logic             eject_done;
    logic             eject_25;
    logic             eject_10;
    logic             eject_5;
    logic             down_25;
    logic             down_10;
    logic             down_5;
    logic             busy;
    logic             fault;

    modport master (
        input  coin_return, coinCount, eject_ready, eject_done,
        output eject_25, eject_10, eject_5, down_25, down_10, down_5, busy, fault
    );

    modport slave (
        output coin_return, coinCount, eject_ready, eject_done,
        input  eject_25, eject_10, eject_5, down_25, down_10, down_5, busy, fault
    );
endinterface

// File: rtl/change_dispenser.sv
// Change-return controller: pays the counter balance out greedily as 25/10/5c coins.
// Latency: k+4 cycles per coin (k = ejector response), plus one SELECT cycle to finish.
// Backpressure: stalls indefinitely on eject_ready; faults after TIMEOUT cycles without eject_done.
module change_dispenser #(
    parameter int WIDTH   = 6,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    change_dispenser_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        WAIT_RDY = 3'd2,
        EJECT    = 3'd3,
        DEBIT    = 3'd4,
        SETTLE   = 3'd5
    } state_t;

    state_t        state_q, state_d;
    // Coin vectors are one-hot {quarter, dime, nickel}.
    logic [2:0]    coin_q, coin_d;
    logic [2:0]    eject_q, eject_d;
    logic [2:0]    down_q, down_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          busy_q, busy_d;
    logic          fault_q, fault_d;
    logic          timed_out;

    assign timed_out = (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            coin_q  <= '0;
            eject_q <= '0;
            down_q  <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            coin_q  <= coin_d;
            eject_q <= eject_d;
            down_q  <= down_d;
            timer_q <= timer_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.coin_return) state_d = SELECT;
            SELECT:   state_d = (bus.coinCount == '0) ? IDLE : WAIT_RDY;
            WAIT_RDY: if (bus.eject_ready) state_d = EJECT;
            EJECT: begin
                // A done arriving on the last allowed cycle still counts as success.
                if (bus.eject_done)  state_d = DEBIT;
                else if (timed_out)  state_d = IDLE;
            end
            DEBIT:    state_d = SETTLE;
            SETTLE:   state_d = SELECT;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin : next_outputs
        coin_d  = coin_q;
        timer_d = '0;
        fault_d = fault_q;
        if (state_q == SELECT) begin
            if (bus.coinCount >= WIDTH'(5))      coin_d = 3'b100;
            else if (bus.coinCount >= WIDTH'(2)) coin_d = 3'b010;
            else                                 coin_d = 3'b001;
        end
        if (state_q == EJECT) timer_d = timer_q + TW'(1);
        if (state_q == IDLE && bus.coin_return) fault_d = 1'b0;
        if (state_q == EJECT && !bus.eject_done && timed_out) fault_d = 1'b1;
        // Outputs are computed from the next state so they are registered yet aligned with it.
        eject_d = (state_d == EJECT) ? coin_d : 3'b000;
        down_d  = (state_d == DEBIT) ? coin_q : 3'b000;
        busy_d  = (state_d != IDLE);
    end

    assign bus.eject_25 = eject_q[2];
    assign bus.eject_10 = eject_q[1];
    assign bus.eject_5  = eject_q[0];
    assign bus.down_25  = down_q[2];
    assign bus.down_10  = down_q[1];
    assign bus.down_5   = down_q[0];
    assign bus.busy     = busy_q;
    assign bus.fault    = fault_q;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: models the coin counter and ejector, predicts payouts greedily.
// Drives inputs on the falling edge and samples outputs there.
module tb_change_dispenser;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset_n;

    change_dispenser_if #(.WIDTH(6)) bus ();

    change_dispenser #(.WIDTH(6), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_bad;
    int bal;
    int ej_cnt;
    int k_now;
    int k_fix;
    int k_sum;
    int first_ej;
    int last_len;
    int last_done;
    int onehot_bad;
    int debit_bad;
    int rdy_low;
    bit done_en;
    bit poke_en;
    int ej_log[$];
    int dn_log[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d want=%0d", tag, got, exp);
        end
    endtask

    // One cycle of the counter/ejector environment, then advance to the next falling edge.
    task automatic step(input int j);
        int ne;
        int nd;
        int c;
        ne = int'(bus.eject_25) + int'(bus.eject_10) + int'(bus.eject_5);
        nd = int'(bus.down_25) + int'(bus.down_10) + int'(bus.down_5);
        if (ne > 1) onehot_bad++;
        if (nd > 1) onehot_bad++;
        if (nd == 1) begin
            c = bus.down_25 ? 25 : (bus.down_10 ? 10 : 5);
            dn_log.push_back(c);
            if (c != last_done) debit_bad++;
            last_done = 0;
            bal = bal - c / 5;
            if (bal < 0) begin
                debit_bad++;
                bal = 0;
            end
        end
        bus.eject_done = 1'b0;
        if (ne == 1) begin
            c = bus.eject_25 ? 25 : (bus.eject_10 ? 10 : 5);
            ej_cnt++;
            if (ej_cnt == 1) begin
                ej_log.push_back(c);
                if (first_ej < 0) first_ej = j;
                k_now = (k_fix > 0) ? k_fix : int'($urandom_range(1, 4));
                k_sum += k_now;
            end
            last_len = ej_cnt;
            if (done_en && ej_cnt == k_now) begin
                bus.eject_done = 1'b1;
                last_done = c;
            end
        end else begin
            ej_cnt = 0;
        end
        if (rdy_low > 0) begin
            bus.eject_ready = 1'b0;
            rdy_low--;
        end else begin
            bus.eject_ready = 1'b1;
        end
        bus.coin_return = poke_en ? 1'($urandom_range(0, 1)) : 1'b0;
        bus.coinCount   = 6'(bal);
        @(negedge clk);
    endtask

    // Request change for balance b; rdy_edges = clock edges (from the request edge) with ejector not ready.
    task automatic payout(input string tag, input int b, input int kfix, input bit en_done,
                          input int rdy_edges, input bit poke);
        int exp_c[$];
        int r;
        int busy_cyc;
        int exp_busy;
        int wait_edges;
        int dn_diff;
        r = b % 5;
        repeat (b / 5) exp_c.push_back(25);
        repeat (r / 2) exp_c.push_back(10);
        repeat (r % 2) exp_c.push_back(5);
        ej_log.delete();
        dn_log.delete();
        k_sum = 0; first_ej = -1; last_len = 0; last_done = 0;
        onehot_bad = 0; debit_bad = 0; ej_cnt = 0;
        k_fix = kfix; done_en = en_done;
        bal = b;
        bus.coinCount   = 6'(b);
        bus.coin_return = 1'b1;
        if (rdy_edges > 0) begin
            bus.eject_ready = 1'b0;
            rdy_low = rdy_edges - 1;
        end else begin
            bus.eject_ready = 1'b1;
            rdy_low = 0;
        end
        @(negedge clk);
        bus.coin_return = 1'b0;
        poke_en = poke;
        chk({tag, ":busy_rise"}, int'(bus.busy), 1);
        chk({tag, ":fault_clr"}, int'(bus.fault), 0);
        busy_cyc = 0;
        while (bus.busy && busy_cyc < 2000) begin
            step(busy_cyc);
            busy_cyc++;
        end
        poke_en = 1'b0;
        bus.coin_return = 1'b0;
        chk({tag, ":finished"}, int'(!bus.busy), 1);
        chk({tag, ":onehot"}, onehot_bad, 0);
        chk({tag, ":debit_ok"}, debit_bad, 0);
        if (en_done) begin
            wait_edges = (rdy_edges > 2) ? rdy_edges : 2;
            exp_busy = (exp_c.size() == 0) ? 1 : 4 * exp_c.size() + k_sum + 1 + (wait_edges - 2);
            chk({tag, ":busy_cycles"}, busy_cyc, exp_busy);
            chk({tag, ":n_eject"}, ej_log.size(), exp_c.size());
            chk({tag, ":n_down"}, dn_log.size(), exp_c.size());
            for (int i = 0; i < exp_c.size(); i++)
                chk({tag, ":coin"}, (i < ej_log.size()) ? ej_log[i] : -1, exp_c[i]);
            dn_diff = 0;
            for (int i = 0; i < dn_log.size(); i++)
                if (i >= exp_c.size() || dn_log[i] != exp_c[i]) dn_diff++;
            chk({tag, ":down_order"}, dn_diff, 0);
            chk({tag, ":bal_zero"}, bal, 0);
            chk({tag, ":fault"}, int'(bus.fault), 0);
            if (exp_c.size() > 0) chk({tag, ":first_eject"}, first_ej, wait_edges);
        end else begin
            chk({tag, ":eject_len"}, last_len, TIMEOUT);
            chk({tag, ":fault_set"}, int'(bus.fault), 1);
            chk({tag, ":eject_off"}, int'({bus.eject_25, bus.eject_10, bus.eject_5}), 0);
            chk({tag, ":no_down"}, dn_log.size(), 0);
            chk({tag, ":bal_kept"}, bal, b);
            chk({tag, ":busy_cycles"}, busy_cyc, 2 + TIMEOUT);
            if (exp_c.size() > 0) chk({tag, ":coin"}, (ej_log.size() > 0) ? ej_log[0] : -1, exp_c[0]);
        end
    endtask

    initial begin
        int b;
        int rd;
        int cnt;
        n_chk = 0; n_bad = 0; bal = 0; ej_cnt = 0; k_now = 1; k_fix = 1;
        rdy_low = 0; done_en = 1'b1; poke_en = 1'b0;
        reset_n         = 1'b1;
        bus.coin_return = 1'b0;
        bus.coinCount   = '0;
        bus.eject_ready = 1'b1;
        bus.eject_done  = 1'b0;
        #1 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst:eject", int'({bus.eject_25, bus.eject_10, bus.eject_5}), 0);
        chk("rst:down", int'({bus.down_25, bus.down_10, bus.down_5}), 0);
        chk("rst:busy", int'(bus.busy), 0);
        chk("rst:fault", int'(bus.fault), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle:busy", int'(bus.busy), 0);

        payout("bal8", 8, 2, 1'b1, 0, 1'b0);
        payout("bal0", 0, 2, 1'b1, 0, 1'b0);
        payout("bal63", 63, 1, 1'b1, 0, 1'b0);
        payout("tmo", 7, 0, 1'b0, 0, 1'b0);
        payout("resume", 7, 0, 1'b1, 0, 1'b0);
        payout("rdy_wait", 9, 2, 1'b1, 12, 1'b1);

        for (int i = 0; i < 20; i++) begin
            b  = int'($urandom_range(0, 63));
            rd = int'($urandom_range(0, 6));
            if (rd == 1) rd = 0;
            payout("rand", b, 0, 1'b1, rd, 1'($urandom_range(0, 1)));
        end

        // Reset while a quarter is being ejected: no debit may follow.
        done_en = 1'b0; k_fix = 1; poke_en = 1'b0; rdy_low = 0;
        ej_log.delete(); dn_log.delete(); ej_cnt = 0; last_done = 0;
        bal = 12;
        bus.coinCount   = 6'(12);
        bus.coin_return = 1'b1;
        @(negedge clk);
        bus.coin_return = 1'b0;
        cnt = 0;
        while (ej_cnt < 3 && cnt < 50) begin
            step(cnt);
            cnt++;
        end
        chk("rst_mid:eject_seen", int'(bus.eject_25), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid:eject", int'({bus.eject_25, bus.eject_10, bus.eject_5}), 0);
        chk("rst_mid:busy", int'(bus.busy), 0);
        chk("rst_mid:fault", int'(bus.fault), 0);
        chk("rst_mid:down", int'({bus.down_25, bus.down_10, bus.down_5}), 0);
        @(negedge clk);
        reset_n = 1'b1;
        done_en = 1'b1;
        for (int i = 0; i < 4; i++) step(i);
        chk("rst_mid:idle", int'(bus.busy), 0);
        chk("rst_mid:no_down", dn_log.size(), 0);
        chk("rst_mid:bal", bal, 12);
        chk("rst_mid:eject_after", int'({bus.eject_25, bus.eject_10, bus.eject_5}), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
